// File: rtl/seg_rx_pkg.sv
// Shared types and constants for the seg_shift_rx serial frame receiver.
// The glitch filter is enabled in seg_shift_rx by SEG_SHIFT_RX_GLITCH_FILTER_EN.
package seg_rx_pkg;

  localparam int unsigned FRAME_BITS_DEF = 64;
  localparam int unsigned CNT_W          = $clog2(FRAME_BITS_DEF + 2);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } rx_state_e;

  // Post-synchronizer conditioning applied before edge detection
  typedef enum logic [1:0] {
    FiltNone,
    FiltDelay,
    FiltMajority
  } filt_mode_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with optional delay/majority conditioning and
// single-cycle rise/fall pulses derived from the conditioned level.
module sync_edge
  import seg_rx_pkg::*;
#(
  parameter int unsigned Stages = 2,
  parameter filt_mode_e  Mode   = FiltNone
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              synced;
  logic              filt;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d_i;
  end

  assign synced = sync_q[Stages-1];

  generate
    if (Mode == FiltNone) begin : g_none
      assign filt = synced;
    end else if (Mode == FiltDelay) begin : g_delay
      // Matches the majority window latency so data/enable stay aligned with the clock
      logic [1:0] dly_q, dly_d;
      always_comb dly_d = {dly_q[0], synced};
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dly_q <= '0;
        else         dly_q <= dly_d;
      end
      assign filt = dly_q[1];
    end else begin : g_maj
      logic [2:0] win_q, win_d;
      always_comb win_d = {win_q[1:0], synced};
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) win_q <= '0;
        else         win_q <= win_d;
      end
      assign filt = maj3(win_q);
    end
  endgenerate

  always_comb prev_d = filt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = filt;
  assign rise_o  = filt & ~prev_q;
  assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/seg_shift_rx.sv
// Serial segclk/ledclk frame receiver with valid/ready output and sticky errors.
// Define SEG_SHIFT_RX_GLITCH_FILTER_EN to add a 3-sample majority filter on s_clk.
module seg_shift_rx
  import seg_rx_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  s_clk,
  input  logic                  s_do,
  input  logic                  s_pen,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  len_err,
  output logic                  ovf_err,
  input  logic                  err_clr
);

  localparam int unsigned CntW = (FRAME_BITS == FRAME_BITS_DEF) ? CNT_W :
                                 $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  localparam filt_mode_e ClkMode   = FiltMajority;
  localparam filt_mode_e AlignMode = FiltDelay;
`else
  localparam filt_mode_e ClkMode   = FiltNone;
  localparam filt_mode_e AlignMode = FiltNone;
`endif

  logic sclk_level, sclk_rise, sclk_fall;
  logic sdo_level, sdo_rise, sdo_fall;
  logic spen_level, spen_rise, spen_fall;

  sync_edge #(
    .Stages (SYNC_STAGES),
    .Mode   (ClkMode)
  ) u_sync_sclk (
    .clk_i   (clk),
    .rst_ni  (RSTN),
    .d_i     (s_clk),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(
    .Stages (SYNC_STAGES),
    .Mode   (AlignMode)
  ) u_sync_sdo (
    .clk_i   (clk),
    .rst_ni  (RSTN),
    .d_i     (s_do),
    .level_o (sdo_level),
    .rise_o  (sdo_rise),
    .fall_o  (sdo_fall)
  );

  sync_edge #(
    .Stages (SYNC_STAGES),
    .Mode   (AlignMode)
  ) u_sync_spen (
    .clk_i   (clk),
    .rst_ni  (RSTN),
    .d_i     (s_pen),
    .level_o (spen_level),
    .rise_o  (spen_rise),
    .fall_o  (spen_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_level, sclk_fall, sdo_rise, sdo_fall, spen_level};

  rx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  len_err_q, len_err_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  latch_ok, latch_bad, handshake;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    latch_ok  = 1'b0;
    latch_bad = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (spen_fall) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // A coincident final clock edge is shifted here before LATCH evaluates the count
        if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], sdo_level};
          if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
        end
        if (spen_rise) state_d = StLatch;
      end
      StLatch: begin
        state_d = StIdle;
        if (cnt_q == CntFull) latch_ok = 1'b1;
        else                  latch_bad = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    handshake     = frame_valid_q & frame_ready;
    frame_data_d  = latch_ok ? shreg_q : frame_data_q;
    frame_valid_d = latch_ok | (frame_valid_q & ~handshake);
    // Error sets take priority over a simultaneous clear
    len_err_d     = latch_bad | (len_err_q & ~err_clr);
    ovf_err_d     = (latch_ok & frame_valid_q & ~handshake) | (ovf_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      len_err_q     <= len_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign len_err     = len_err_q;
  assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_seg_shift_rx.sv
// Directed bench for seg_shift_rx: frame capture, length/overflow errors, reset
// mid-frame, coincident edges and (with SEG_SHIFT_RX_GLITCH_FILTER_EN) glitch rejection.
module tb_seg_shift_rx;

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  localparam int Lat = 6;
`else
  localparam int Lat = 4;
`endif

  localparam logic [63:0] FrmA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FrmB = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] FrmD = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] FrmE = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] AllA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] All5 = 64'h5555_5555_5555_5555;

  logic        clk = 1'b0;
  logic        RSTN;
  logic        s_clk, s_do, s_pen;
  logic [63:0] frame_data;
  logic        frame_valid, frame_ready, len_err, ovf_err, err_clr;

  int n_checks = 0;
  int n_pass   = 0;

  seg_shift_rx dut (
    .clk         (clk),
    .RSTN        (RSTN),
    .s_clk       (s_clk),
    .s_do        (s_do),
    .s_pen       (s_pen),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .len_err     (len_err),
    .ovf_err     (ovf_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic shift_bit(input logic b, input bit glitch, input bit pen_with_edge);
    s_clk = 1'b0;
    s_do  = b;
    repeat (2) @(negedge clk);
    if (glitch) begin
      s_clk = 1'b1;
      @(negedge clk);
      s_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
    s_clk = 1'b1;
    if (pen_with_edge) s_pen = 1'b1;
    else begin
      repeat (4) @(negedge clk);
      s_clk = 1'b0;
    end
  endtask

  // Returns on the negedge where s_pen rises.
  task automatic send_frame(input logic [127:0] data, input int nbits, input bit coinc,
                            input int glitch_bit);
    s_clk = 1'b0;
    s_pen = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i], i == glitch_bit, coinc && i == 0);
    if (!coinc) begin
      repeat (3) @(negedge clk);
      s_pen = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    RSTN = 1'b0; s_clk = 1'b0; s_do = 1'b0; s_pen = 1'b1;
    frame_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 64'(frame_valid), 64'd0);
    check_eq("rst_data", frame_data, 64'd0);
    check_eq("rst_len", 64'(len_err), 64'd0);
    check_eq("rst_ovf", 64'(ovf_err), 64'd0);
    RSTN = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 64-bit frame, consumer always ready
    send_frame({64'd0, FrmA}, 64, 1'b0, -1);
    repeat (Lat - 1) @(negedge clk);
    check_eq("a_early", 64'(frame_valid), 64'd0);
    @(negedge clk);
    check_eq("a_valid", 64'(frame_valid), 64'd1);
    check_eq("a_data", frame_data, FrmA);
    check_eq("a_len", 64'(len_err), 64'd0);
    @(negedge clk);
    check_eq("a_1cyc", 64'(frame_valid), 64'd0);

    // 63-bit frame: length error, data untouched
    send_frame(128'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("s63_len", 64'(len_err), 64'd1);
    check_eq("s63_valid", 64'(frame_valid), 64'd0);
    check_eq("s63_data", frame_data, FrmA);
    pulse_clr();
    check_eq("s63_clr", 64'(len_err), 64'd0);

    // err_clr in the same cycle as the length error set
    send_frame(128'h0, 63, 1'b0, -1);
    repeat (Lat - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("setwin_len", 64'(len_err), 64'd1);
    pulse_clr();
    check_eq("setwin_clr", 64'(len_err), 64'd0);

    // 70-bit frame: counter saturates, still a length error
    send_frame(128'h3F_FFFF_FFFF_FFFF_FFFF, 70, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("l70_len", 64'(len_err), 64'd1);
    check_eq("l70_data", frame_data, FrmA);
    pulse_clr();

    // Overflow: two frames with no consumer
    frame_ready = 1'b0;
    send_frame({64'd0, AllA}, 64, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("ov1_valid", 64'(frame_valid), 64'd1);
    check_eq("ov1_data", frame_data, AllA);
    check_eq("ov1_ovf", 64'(ovf_err), 64'd0);
    send_frame({64'd0, All5}, 64, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("ov2_data", frame_data, All5);
    check_eq("ov2_ovf", 64'(ovf_err), 64'd1);
    check_eq("ov2_valid", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check_eq("ov_hs", 64'(frame_valid), 64'd0);
    pulse_clr();
    check_eq("ov_clr", 64'(ovf_err), 64'd0);

    // s_clk toggles while idle must not disturb the next frame
    repeat (3) begin
      s_clk = 1'b1;
      repeat (4) @(negedge clk);
      s_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
    send_frame({64'd0, FrmB}, 64, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("idle_data", frame_data, FrmB);
    check_eq("idle_valid", 64'(frame_valid), 64'd1);

    // Reset after 30 bits, then a clean frame
    s_pen = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 63; i > 33; i--) shift_bit(FrmE[i], 1'b0, 1'b0);
    RSTN = 1'b0;
    @(negedge clk);
    check_eq("mr_rst_data", frame_data, 64'd0);
    check_eq("mr_rst_valid", 64'(frame_valid), 64'd0);
    RSTN = 1'b1;
    repeat (4) @(negedge clk);
    s_pen = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("mr_novalid", 64'(frame_valid), 64'd0);
    check_eq("mr_nolen", 64'(len_err), 64'd0);
    send_frame({64'd0, FrmD}, 64, 1'b0, -1);
    repeat (Lat) @(negedge clk);
    check_eq("mr_data", frame_data, FrmD);
    check_eq("mr_len", 64'(len_err), 64'd0);

    // Final s_clk edge coincident with s_pen rise
    send_frame({64'd0, FrmE}, 64, 1'b1, -1);
    repeat (Lat) @(negedge clk);
    check_eq("co_valid", 64'(frame_valid), 64'd1);
    check_eq("co_data", frame_data, FrmE);
    check_eq("co_len", 64'(len_err), 64'd0);

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
    send_frame(128'h1122_3344_5566_7788, 64, 1'b0, 40);
    repeat (Lat) @(negedge clk);
    check_eq("gl_data", frame_data, 64'h1122_3344_5566_7788);
    check_eq("gl_len", 64'(len_err), 64'd0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
